// File: rtl/ili_spi_tx_pkg.sv
// pkg_ili9341: shared types and constants for the ILI9341 panel interface blocks.
package pkg_ili9341;
    typedef enum logic [1:0] {SPI_IDLE, SPI_LOW, SPI_HIGH, SPI_TAIL} spi_state_t;
    localparam logic DC_CMD          = 1'b0;
    localparam logic DC_DATA         = 1'b1;
    localparam int   SPI_CLK_DIV_DEF = 2;
endpackage

// File: rtl/ili_spi_tx.sv
// ili_spi_tx: serializes one DW-bit word MSB-first in SPI mode 0 and drives CS_n/DC for the ILI9341.
// A one-cycle done strobe paces the upstream command sequencer; sends while busy are dropped.
module ili_spi_tx
    import pkg_ili9341::*;
#(
    parameter int DW      = 8,
    parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send_i,
    input  logic [DW-1:0] data_i,
    input  logic          dc_in_i,
    input  logic          cs_hold_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          spi_sck_o,
    output logic          spi_mosi_o,
    output logic          spi_dc_o,
    output logic          spi_cs_n_o
);
    localparam int DIVW = $clog2(CLK_DIV + 1);
    localparam int BW   = (DW > 1) ? $clog2(DW) : 1;

    spi_state_t    state_q, state_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [DW-1:0] data_q, data_d;
    logic          hold_q, hold_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          dc_q, dc_d;
    logic          cs_n_q, cs_n_d;
    logic          done_q, done_d;
    logic          div_last;

    assign div_last   = (div_q == DIVW'(CLK_DIV - 1));
    assign busy_o     = (state_q != SPI_IDLE);
    assign done_o     = done_q;
    assign spi_sck_o  = sck_q;
    assign spi_mosi_o = mosi_q;
    assign spi_dc_o   = dc_q;
    assign spi_cs_n_o = cs_n_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SPI_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            hold_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            dc_q    <= DC_DATA;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            hold_q  <= hold_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            dc_q    <= dc_d;
            cs_n_q  <= cs_n_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        data_d  = data_q;
        hold_d  = hold_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        dc_d    = dc_q;
        cs_n_d  = cs_n_q;
        done_d  = 1'b0;
        case (state_q)
            SPI_IDLE: if (send_i) begin
                data_d  = data_i;
                hold_d  = cs_hold_i;
                cs_n_d  = 1'b0;
                dc_d    = dc_in_i;
                mosi_d  = data_i[DW-1];
                bit_d   = BW'(DW - 1);
                div_d   = '0;
                state_d = SPI_LOW;
            end
            SPI_LOW: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) begin
                    sck_d   = 1'b1;
                    state_d = SPI_HIGH;
                end
            end
            SPI_HIGH: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                if (div_last) begin
                    sck_d   = 1'b0;
                    state_d = (bit_q != '0) ? SPI_LOW : SPI_TAIL;
                    if (bit_q != '0) begin
                        bit_d  = bit_q - 1'b1;
                        mosi_d = data_q[bit_q - 1'b1];
                    end
                end
            end
            SPI_TAIL: begin
                div_d = div_last ? '0 : div_q + 1'b1;
                // CS release (or hold for the next word) coincides with done
                if (div_last) begin
                    cs_n_d  = ~hold_q;
                    done_d  = 1'b1;
                    state_d = SPI_IDLE;
                end
            end
            default: state_d = SPI_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ili_spi_tx.sv
// tb_ili_spi_tx: scoreboard bench; stimulus queues expected words, an SPI-slave monitor checks each completed word.
module tb_ili_spi_tx;
    typedef struct {
        logic [7:0] d;
        logic       dc;
        logic       hold;
        int         acc;
    } item_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       send = 1'b0;
    logic [7:0] data = '0;
    logic       dc_in = 1'b0;
    logic       cs_hold = 1'b0;
    logic       busy, done, sck, mosi, dc, cs_n;

    logic       s1_send = 1'b0;
    logic [7:0] s1_data = '0;
    logic       s1_busy, s1_done, s1_sck, s1_mosi, s1_dc, s1_cs_n;

    item_t q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    n_done = 0;
    int    last_done_cyc = 0;

    ili_spi_tx #(.DW(8), .CLK_DIV(2)) dut (
        .clk(clk), .rst(rst), .send_i(send), .data_i(data), .dc_in_i(dc_in),
        .cs_hold_i(cs_hold), .busy_o(busy), .done_o(done), .spi_sck_o(sck),
        .spi_mosi_o(mosi), .spi_dc_o(dc), .spi_cs_n_o(cs_n)
    );

    ili_spi_tx #(.DW(8), .CLK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .send_i(s1_send), .data_i(s1_data), .dc_in_i(1'b1),
        .cs_hold_i(1'b0), .busy_o(s1_busy), .done_o(s1_done), .spi_sck_o(s1_sck),
        .spi_mosi_o(s1_mosi), .spi_dc_o(s1_dc), .spi_cs_n_o(s1_cs_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // SPI-slave model: samples mosi on sck rising edges, compares the word at done
    logic       sck_prev = 1'b0;
    logic       mosi_prev = 1'b0;
    logic [7:0] word = '0;
    int         nbits = 0;
    item_t      it;
    always @(negedge clk) begin
        if (!rst) begin
            nbits = 0;
            word  = '0;
        end else begin
            if (sck && !sck_prev) begin
                word = {word[6:0], mosi};
                nbits++;
                check("cs_low_on_sck", int'(cs_n), 0);
                if (q.size() != 0) check("dc_on_sck", int'(dc), int'(q[0].dc));
            end
            if (sck && sck_prev) check("mosi_stable_high", int'(mosi), int'(mosi_prev));
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected got done=1 expected done=0");
                end else begin
                    it = q.pop_front();
                    check("word", int'(word), int'(it.d));
                    check("bit_count", nbits, 8);
                    check("dc_word", int'(dc), int'(it.dc));
                    check("cs_after_done", int'(cs_n), int'(!it.hold));
                    check("busy_at_done", int'(busy), 0);
                    check("done_latency", cyc - it.acc, 34);
                end
                nbits = 0;
                word  = '0;
                n_done++;
                last_done_cyc = cyc;
            end
        end
        sck_prev  = sck;
        mosi_prev = mosi;
    end

    task automatic send_word(input logic [7:0] d, input logic dcv, input logic hold, output int acc);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", int'(busy), 0);
        acc = cyc + 1;
        q.push_back('{d, dcv, hold, acc});
        send = 1'b1; data = d; dc_in = dcv; cs_hold = hold;
        @(negedge clk);
        send = 1'b0; data = $urandom; dc_in = $urandom; cs_hold = $urandom;
    endtask

    initial begin
        int acc, n, nd, nb, last_rise;
        logic [7:0] w;
        logic prev;
        @(negedge clk);
        check("rst_sck", int'(sck), 0);
        check("rst_mosi", int'(mosi), 0);
        check("rst_dc", int'(dc), 1);
        check("rst_cs_n", int'(cs_n), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // async reset mid-word discards the partial word
        send_word(8'h5A, 1'b0, 1'b1, acc);
        while (cyc < acc + 10) @(negedge clk);
        #2 rst = 1'b0;
        q.delete();
        @(negedge clk);
        check("midrst_sck", int'(sck), 0);
        check("midrst_cs_n", int'(cs_n), 1);
        check("midrst_dc", int'(dc), 1);
        check("midrst_busy", int'(busy), 0);
        nd = n_done;
        @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_no_done", n_done, nd);

        send_word(8'h2A, 1'b0, 1'b0, acc);

        // back-to-back frame with CS held low
        send_word(8'h36, 1'b0, 1'b1, acc);
        send_word(8'h48, 1'b1, 1'b1, acc);
        check("b2b_accept_2", acc - last_done_cyc, 1);
        send_word(8'h00, 1'b1, 1'b0, acc);
        check("b2b_accept_3", acc - last_done_cyc, 1);

        // send during busy is ignored
        send_word(8'h01, 1'b0, 1'b0, acc);
        nd = n_done;
        repeat (4) @(negedge clk);
        send = 1'b1; data = 8'hFF; dc_in = 1'b1;
        @(negedge clk);
        send = 1'b0;
        n = 0;
        while (n_done == nd && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (40) @(negedge clk);
        check("busy_ignore_one_done", n_done - nd, 1);

        // CLK_DIV=1 instance
        s1_send = 1'b1; s1_data = 8'hA5; acc = cyc + 1;
        @(negedge clk);
        s1_send = 1'b0; s1_data = 8'h00;
        w = '0; nb = 0; prev = 1'b0; n = 0; last_rise = 0;
        while (!s1_done && n < 60) begin
            if (s1_sck && !prev) begin
                w = {w[6:0], s1_mosi};
                if (nb != 0) check("div1_sck_period", cyc - last_rise, 2);
                nb++;
                last_rise = cyc;
            end
            prev = s1_sck;
            @(negedge clk);
            n++;
        end
        check("div1_done_seen", int'(s1_done), 1);
        check("div1_latency", cyc - acc, 17);
        check("div1_word", int'(w), 8'hA5);
        check("div1_bits", nb, 8);
        check("div1_cs_n", int'(s1_cs_n), 1);
        check("div1_dc", int'(s1_dc), 1);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send_word(8'($urandom), 1'($urandom), 1'($urandom), acc);
        end

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
